serial_frame_transmitter: RTL and testbench
===========================================

# serial_frame_transmitter

Serial transmitter that emits frames in the format accepted by the team's serial sequence detector. On a start request it sends the 4-bit preamble 1101, then a fixed-width payload MSB first. Bits advance only on the shared clk_en bit strobe. It sits on the sending side of the single-wire serial link and drives the receiver's SerIn.

## Interface
- PAYLOAD_W, default 8: payload bits per frame, legal range 2..32.
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- clk_en  input  1  bit strobe; one serial bit is consumed per clk cycle with clk_en=1.
- start  input  1  frame request; sampled only when ready=1.
- data_in  input  PAYLOAD_W  payload; captured on the accepting edge.
- SerOut  output  1  serial line, registered; idles at 0.
- ready  output  1  high in IDLE; start is accepted.
- busy  output  1  high from frame acceptance until the last bit is consumed.
- done  output  1  one-cycle pulse after the last bit is consumed.

## Operation
- States: IDLE, PRE, DATA, PAR (exists only with the parity feature), DONE.
- IDLE: SerOut=0, ready=1, busy=0.
  - On start=1 at a clk edge: latch data_in into the shift register, clear bit_cnt, and go to PRE. clk_en in the same cycle is ignored.
- PRE: SerOut = preamble bit bit_cnt, with preamble 1,1,0,1 in order.
  - On each clk_en=1 edge, bit_cnt increments.
  - After the 4th strobe, go to DATA with bit_cnt=0.
- DATA: SerOut = shift register MSB.
  - On each clk_en=1 edge, shift left and increment bit_cnt.
  - After PAYLOAD_W strobes, go to PAR if the parity feature is compiled in, otherwise to DONE.
- PAR: SerOut = even-parity bit of the captured payload. It is consumed on one clk_en=1 edge, then go to DONE.
- DONE: lasts exactly one cycle regardless of clk_en. done=1, busy=0, SerOut=0. Next state is IDLE.
- Without strobes, the FSM holds its state and SerOut holds its value indefinitely.
- start while busy or in DONE: ignored, not queued.
- data_in changes after acceptance: no effect on the frame in flight.
- bit_cnt width: $clog2(PAYLOAD_W+1). Comparisons use a constant of the same width, with no truncation.
- Reset (rst=0), asynchronous at any point including mid-frame:
  - state=IDLE, SerOut=0, ready=1, busy=0, done=0, bit_cnt=0, shift register=0.
  - The partial frame is abandoned.
- Idle level 0 before the first preamble 1 guarantees the receiver sees a clean 1101.

## Timing
- Acceptance edge to first preamble bit on SerOut: 1 clk cycle.
- Each bit is valid on SerOut from the edge that makes it current until the next clk_en=1 edge. The receiver samples on that same strobe edge.
- Frame length is 4+PAYLOAD_W strobes, or 5+PAYLOAD_W with parity.
- done rises 1 clk after the final bit's strobe edge and stays high for exactly 1 cycle.
- ready rises 1 cycle after done.
- Minimum spacing between acceptances: frame strobes + 2 clk.
- Outputs are registered, with no combinational path from inputs to outputs.

## Configuration
- FRAME_PARITY_EN defined:
  - PAR state is present.
  - One extra bit, the XOR of all payload bits (even parity), is sent after the payload.
  - Frame length is 5+PAYLOAD_W strobes.
- Not defined:
  - PAR state and parity logic are absent.
  - DATA goes directly to DONE.
  - Frame length is 4+PAYLOAD_W strobes.

## Test plan
- Reset check: hold rst=0 for 3 cycles. Required: SerOut=0, ready=1, busy=0, done=0. Release rst, with start=0 for 10 cycles. Required: outputs unchanged.
- Basic frame: PAYLOAD_W=8, data_in=0xA5, clk_en every 4th cycle, no parity.
  - SerOut over strobes: 1,1,0,1,1,0,1,0,0,1,0,1.
  - done is a single pulse 1 cycle after strobe 12.
  - ready=1 one cycle later.
- Parity frame: FRAME_PARITY_EN defined, data_in=0x07.
  - SerOut: 1,1,0,1,0,0,0,0,0,1,1,1, then parity bit 1.
  - done follows strobe 13.
- Stalled strobe plus ignored start: clk_en held 0 for 20 cycles mid-payload.
  - Required: SerOut constant, state unchanged.
  - start pulses during busy produce no second frame.
  - A new data_in value does not alter the payload in flight.
- Simultaneous start and clk_en in IDLE: start=1 and clk_en=1 on the same edge, data_in=0xFF.
  - Required: no bit consumed on that edge; the first preamble 1 lasts until the next strobe.
  - Full 12-strobe frame follows.
- Reset mid-payload: assert rst=0 asynchronously (between clk edges) after strobe 6.
  - Required immediately: SerOut=0, ready=1, no done pulse.
  - After release, a new start with data_in=0x3C sends a complete fresh frame 1,1,0,1,0,0,1,1,1,1,0,0.

Source files
------------

// File: rtl/serial_frame_transmitter_if.sv
// Serial frame transmitter bus: strobe, frame request/payload in, serial line and status out.
interface serial_frame_transmitter_if #(
  parameter int unsigned PAYLOAD_W = 8
);
  logic                 clk_en;
  logic                 start;
  logic [PAYLOAD_W-1:0] data_in;
  logic                 SerOut;
  logic                 ready;
  logic                 busy;
  logic                 done;

  // Frame source side: issues strobes/requests, observes the line
  modport master (
    output clk_en,
    output start,
    output data_in,
    input  SerOut,
    input  ready,
    input  busy,
    input  done
  );

  // Transmitter side
  modport slave (
    input  clk_en,
    input  start,
    input  data_in,
    output SerOut,
    output ready,
    output busy,
    output done
  );
endinterface

// File: rtl/serial_frame_transmitter.sv
// Serial frame transmitter: preamble 1101 followed by a PAYLOAD_W-bit payload sent MSB
// first, one bit per clk_en strobe. Line idles at 0.
// Optional feature macro FRAME_PARITY_EN: appends an even-parity bit after the payload.
module serial_frame_transmitter #(
  parameter int unsigned PAYLOAD_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  serial_frame_transmitter_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(PAYLOAD_W + 1);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(3);
  localparam logic [CNT_W-1:0] DATA_END = CNT_W'(PAYLOAD_W);
  // Preamble bits indexed by transmit order: 1,1,0,1
  localparam logic [3:0]       PREAMBLE = 4'b1011;

`ifdef FRAME_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_DATA = 3'd2,
    S_PAR  = 3'd3,
    S_DONE = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_DATA = 3'd2,
    S_DONE = 3'd4
  } state_t;
`endif

  state_t               r_state;
  logic [CNT_W-1:0]     r_bit_cnt;
  logic [PAYLOAD_W-1:0] r_shift;
  logic                 r_ser_out;
  logic                 r_ready;
  logic                 r_busy;
  logic                 r_done;
`ifdef FRAME_PARITY_EN
  logic                 r_parity;
`endif

  logic [CNT_W-1:0]     w_cnt_inc;
  logic [1:0]           w_pre_idx;

  // Next bit position; preamble index only needs the low two bits
  assign w_cnt_inc = r_bit_cnt + CNT_W'(1);
  assign w_pre_idx = 2'(w_cnt_inc);

  // Frame sequencer; every output is computed one edge ahead so the line is registered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_ser_out <= 1'b0;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
`ifdef FRAME_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Strobe in the accepting cycle is deliberately ignored
          if (bus.start) begin
            r_state   <= S_PRE;
            r_shift   <= bus.data_in;
            r_bit_cnt <= '0;
            r_ser_out <= PREAMBLE[0];
            r_ready   <= 1'b0;
            r_busy    <= 1'b1;
`ifdef FRAME_PARITY_EN
            r_parity  <= ^bus.data_in;
`endif
          end
        end

        S_PRE: begin
          if (bus.clk_en) begin
            if (r_bit_cnt == PRE_LAST) begin
              r_state   <= S_DATA;
              r_bit_cnt <= '0;
              r_ser_out <= r_shift[PAYLOAD_W-1];
            end else begin
              r_bit_cnt <= w_cnt_inc;
              r_ser_out <= PREAMBLE[w_pre_idx];
            end
          end
        end

        S_DATA: begin
          if (bus.clk_en) begin
            r_shift   <= r_shift << 1;
            r_bit_cnt <= w_cnt_inc;
            if (w_cnt_inc == DATA_END) begin
`ifdef FRAME_PARITY_EN
              r_state   <= S_PAR;
              r_ser_out <= r_parity;
`else
              r_state   <= S_DONE;
              r_ser_out <= 1'b0;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
`endif
            end else begin
              // Next MSB after this shift
              r_ser_out <= r_shift[PAYLOAD_W-2];
            end
          end
        end

`ifdef FRAME_PARITY_EN
        S_PAR: begin
          if (bus.clk_en) begin
            r_state   <= S_DONE;
            r_ser_out <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
          end
        end
`endif

        S_DONE: begin
          // Single cycle regardless of strobe; start here is not queued
          r_state   <= S_IDLE;
          r_bit_cnt <= '0;
          r_ready   <= 1'b1;
        end

        default: begin
          r_state   <= S_IDLE;
          r_bit_cnt <= '0;
          r_ser_out <= 1'b0;
          r_ready   <= 1'b1;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.SerOut = r_ser_out;
  assign bus.ready  = r_ready;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;

endmodule

// File: tb/tb_serial_frame_transmitter.sv
// Self-checking bench for serial_frame_transmitter; expected line bits come from a
// frame-level scoreboard filled at acceptance and drained on every strobe.
module tb_serial_frame_transmitter;

  localparam int unsigned PW = 8;

  logic clk;
  logic rst;

  serial_frame_transmitter_if #(.PAYLOAD_W(PW)) bif ();

  serial_frame_transmitter #(.PAYLOAD_W(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit exp_q[$];
  int m_phase = 0;   // 0 idle, 1 frame in flight, 2 done cycle
  int bit_idx = 0;

  // Build the expected serial sequence for one payload
  task automatic push_frame(input logic [PW-1:0] d);
    logic [3:0] pre;
    pre = 4'b1011;
    exp_q.delete();
    bit_idx = 0;
    for (int i = 0; i < 4; i++) exp_q.push_back(pre[i]);
    for (int i = PW - 1; i >= 0; i--) exp_q.push_back(d[i]);
`ifdef FRAME_PARITY_EN
    exp_q.push_back(^d);
`endif
  endtask

  // One clock cycle from a negedge to the next: drive, score consumed bit, check status
  task automatic step(input logic st, input logic en, input logic [PW-1:0] d);
    int   nxt;
    bit   e;
    logic want;
    nxt = m_phase;
    bif.start   = st;
    bif.clk_en  = en;
    bif.data_in = d;
    if (m_phase == 0) begin
      if (st) begin
        push_frame(d);
        nxt = 1;
      end
    end else if (m_phase == 1) begin
      if (en) begin
        e = exp_q.pop_front();
        n_checks++;
        if (bif.SerOut !== e) begin
          n_errors++;
          $display("FAIL serout bit %0d: got %b want %b (t=%0t)", bit_idx, bif.SerOut, e, $time);
        end
        bit_idx++;
        if (exp_q.size() == 0) nxt = 2;
      end
    end else begin
      nxt = 0;
    end
    @(negedge clk);
    m_phase = nxt;
    want = (m_phase == 0);
    n_checks++;
    if (bif.ready !== want) begin
      n_errors++;
      $display("FAIL ready: got %b want %b (t=%0t)", bif.ready, want, $time);
    end
    want = (m_phase == 1);
    n_checks++;
    if (bif.busy !== want) begin
      n_errors++;
      $display("FAIL busy: got %b want %b (t=%0t)", bif.busy, want, $time);
    end
    want = (m_phase == 2);
    n_checks++;
    if (bif.done !== want) begin
      n_errors++;
      $display("FAIL done: got %b want %b (t=%0t)", bif.done, want, $time);
    end
    if (m_phase != 1) begin
      n_checks++;
      if (bif.SerOut !== 1'b0) begin
        n_errors++;
        $display("FAIL serout_idle: got %b want 0 (t=%0t)", bif.SerOut, $time);
      end
    end
  endtask

  // Accept one frame and strobe it out every 'period' cycles until back in idle
  task automatic run_frame(input logic [PW-1:0] d, input int period, input logic simul_en);
    int cyc;
    step(1'b1, simul_en, d);
    cyc = 0;
    while (m_phase != 0 && cyc < 600) begin
      step(1'b0, ((cyc % period) == period - 1), ~d);
      cyc++;
    end
    n_checks++;
    if (m_phase != 0) begin
      n_errors++;
      $display("FAIL frame_timeout: phase %0d after %0d cycles, want 0", m_phase, cyc);
    end
  endtask

  task automatic test_reset();
    bif.start   = 1'b0;
    bif.clk_en  = 1'b0;
    bif.data_in = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (bif.SerOut !== 1'b0 || bif.ready !== 1'b1 || bif.busy !== 1'b0 || bif.done !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_outputs: got ser=%b rdy=%b busy=%b done=%b want 0 1 0 0",
                 bif.SerOut, bif.ready, bif.busy, bif.done);
      end
    end
    rst = 1'b1;
    m_phase = 0;
    for (int i = 0; i < 10; i++) step(1'b0, 1'(i % 2), PW'($urandom));
  endtask

  task automatic test_basic_frame();
    run_frame(8'hA5, 4, 1'b0);
    step(1'b0, 1'b0, '0);
  endtask

  task automatic test_parity_frame();
    run_frame(8'h07, 3, 1'b0);
    run_frame(8'h00, 1, 1'b0);
  endtask

  task automatic test_stall_ignored_start();
    logic hold;
    int   cyc;
    step(1'b1, 1'b0, 8'h96);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 8'h96);
    hold = bif.SerOut;
    for (int i = 0; i < 20; i++) begin
      step(1'(i % 3 == 0), 1'b0, PW'($urandom));
      n_checks++;
      if (bif.SerOut !== hold) begin
        n_errors++;
        $display("FAIL stall_hold cycle %0d: got %b want %b", i, bif.SerOut, hold);
      end
    end
    cyc = 0;
    while (m_phase != 0 && cyc < 100) begin
      step(1'(cyc % 2), 1'b1, PW'($urandom));
      cyc++;
    end
    n_checks++;
    if (m_phase != 0) begin
      n_errors++;
      $display("FAIL stall_timeout: phase %0d want 0", m_phase);
    end
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, '0);
  endtask

  task automatic test_simul_start_strobe();
    run_frame(8'hFF, 2, 1'b1);
  endtask

  task automatic test_reset_mid_payload();
    step(1'b1, 1'b0, 8'h5A);
    for (int i = 0; i < 12; i++) step(1'b0, 1'(i % 2), 8'h5A);
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (bif.SerOut !== 1'b0 || bif.ready !== 1'b1 || bif.busy !== 1'b0 || bif.done !== 1'b0) begin
      n_errors++;
      $display("FAIL async_reset: got ser=%b rdy=%b busy=%b done=%b want 0 1 0 0",
               bif.SerOut, bif.ready, bif.busy, bif.done);
    end
    exp_q.delete();
    m_phase = 0;
    @(negedge clk);
    n_checks++;
    if (bif.done !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_no_done: got %b want 0", bif.done);
    end
    rst = 1'b1;
    run_frame(8'h3C, 2, 1'b0);
  endtask

  task automatic test_back_to_back();
    int cyc;
    int accepts;
    cyc = 0;
    accepts = 0;
    while (accepts < 3 && cyc < 300) begin
      if (m_phase == 0) accepts++;
      step(1'b1, 1'b1, PW'($urandom));
      cyc++;
    end
    while (m_phase != 0 && cyc < 300) begin
      step(1'b0, 1'b1, PW'($urandom));
      cyc++;
    end
    n_checks++;
    if (m_phase != 0 || accepts != 3) begin
      n_errors++;
      $display("FAIL back_to_back: phase %0d accepts %0d want 0 and 3", m_phase, accepts);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_parity_frame();
    test_stall_ignored_start();
    test_simul_start_strobe();
    test_reset_mid_payload();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
